// File: rtl/button_debounce_pkg.sv
// Shared types and helpers for the push-button debouncer.
package button_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button pin plus conditioned outputs; slave is the debouncer, master the consumer.
interface button_debounce_if;
   logic btn_raw;
   logic btn_level;
   logic btn_press;
   logic btn_release;
   logic busy;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  busy
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_press,
      output btn_release,
      output busy
   );
endinterface

// File: rtl/button_debounce_sync.sv
// Multi-flop synchronizer for asynchronous pin inputs; clears to 0 on reset.
module sync_ff #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] chain_q;

   // Shift the pin value through the synchronizer chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
      end
   end

   assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Synchronizes and debounces a raw button, producing a clean level and press/release strobes.
module button_debounce
   import button_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter bit ACTIVE_LOW_IN   = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   button_debounce_if.slave   bus
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          pol_s;
   logic          sync_s;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          busy_q, busy_d;

   // Internally "pressed" is always 1
   assign pol_s = ACTIVE_LOW_IN ? ~bus.btn_raw : bus.btn_raw;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (pol_s),
      .q_o   (sync_s)
   );

   // State, counter and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE_LO;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         busy_q    <= busy_d;
      end
   end

   // Next state and stability count; any reversal during WAIT restarts from zero
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE_LO: begin
            if (sync_s) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT_HI: begin
            if (!sync_s) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         IDLE_HI: begin
            if (!sync_s) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT_LO: begin
            if (sync_s) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
         end
      endcase
   end

   // Output values registered alongside the state they describe
   always_comb begin
      level_d   = (state_d == IDLE_HI) || (state_d == WAIT_LO);
      busy_d    = (state_d == WAIT_HI) || (state_d == WAIT_LO);
      press_d   = (state_q == WAIT_HI) && (state_d == IDLE_HI);
      release_d = (state_q == WAIT_LO) && (state_d == IDLE_LO);
   end

   assign bus.btn_level   = level_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = release_q;
   assign bus.busy        = busy_q;

endmodule
